// File: rtl/serial_digit_recoder.sv
// -----------------------------------------------------------------------------
// serial_digit_recoder
//
// Consumes an unsigned operand Y two bits at a time, least-significant pair
// first. For each slice it emits one radix-4 signed digit in {-1,0,+1,+2}
// over a valid/ready handshake. After the last slice it emits one extra digit
// that carries out the final recoding carry, so that sum(d_i * 4^i) == Y.
//
// The upstream shift register is told to advance through shift_en. shift_en
// is high only while a slice digit is being accepted, so m holds under
// backpressure.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   begin recoding (sampled only while idle)
//   m[1:0]     in   current operand slice from the upstream shift register
//   shift_en   out  upstream advances one slice this cycle
//   dig_valid  out  digit outputs valid
//   dig_ready  in   downstream accepts the digit
//   dig_neg    out  digit is negative
//   dig_one    out  |digit| == 1
//   dig_two    out  |digit| == 2
//   dig_idx    out  digit position i (0..NDIG)
//   busy       out  high while slice digits or the carry digit are offered
//   done       out  one-cycle pulse after the last digit is accepted
//
// WIDTH must be even and at least 2.
// -----------------------------------------------------------------------------
module serial_digit_recoder #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     m,
  output logic                           shift_en,
  output logic                           dig_valid,
  input  logic                           dig_ready,
  output logic                           dig_neg,
  output logic                           dig_one,
  output logic                           dig_two,
  output logic [$clog2(WIDTH/2+1)-1:0]   dig_idx,
  output logic                           busy,
  output logic                           done
);

  localparam int NDIG = WIDTH / 2;
  localparam int IW   = $clog2(NDIG + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NDIG - 1);
  localparam logic [IW-1:0] FLUSH_IDX = IW'(NDIG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   cnt_q,   cnt_d;

  // Slice value plus incoming carry, range 0..4.
  logic [2:0]      v_s;

  // Digit encoding of the current slice and the carry it produces.
  logic            slice_neg_s;
  logic            slice_one_s;
  logic            slice_two_s;
  logic            slice_carry_s;

  assign v_s = {1'b0, m} + {2'b00, carry_q};

  // Recode one slice: 3 becomes -1 with a carry, 4 becomes 0 with a carry.
  always_comb begin
    slice_neg_s   = 1'b0;
    slice_one_s   = 1'b0;
    slice_two_s   = 1'b0;
    slice_carry_s = 1'b0;
    case (v_s)
      3'd0: begin
        slice_carry_s = 1'b0;
      end
      3'd1: begin
        slice_one_s   = 1'b1;
      end
      3'd2: begin
        slice_two_s   = 1'b1;
      end
      3'd3: begin
        slice_neg_s   = 1'b1;
        slice_one_s   = 1'b1;
        slice_carry_s = 1'b1;
      end
      3'd4: begin
        // Digit is zero; no negative zero is ever emitted.
        slice_carry_s = 1'b1;
      end
      default: begin
        slice_carry_s = 1'b0;
      end
    endcase
  end

  // State, carry and digit counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and combinational outputs of the recoding FSM.
  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    dig_valid = 1'b0;
    dig_neg   = 1'b0;
    dig_one   = 1'b0;
    dig_two   = 1'b0;
    dig_idx   = '0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        dig_valid = 1'b1;
        busy      = 1'b1;
        dig_idx   = cnt_q;
        dig_neg   = slice_neg_s;
        dig_one   = slice_one_s;
        dig_two   = slice_two_s;
        // Upstream only moves when this slice's digit is taken.
        shift_en  = dig_ready;
        if (dig_ready) begin
          carry_d = slice_carry_s;
          cnt_d   = cnt_q + IW'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end

      S_FLUSH: begin
        // Final digit is the leftover carry: either 0 or +1.
        dig_valid = 1'b1;
        busy      = 1'b1;
        dig_idx   = FLUSH_IDX;
        dig_one   = carry_q;
        if (dig_ready) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_digit_recoder.sv
// -----------------------------------------------------------------------------
// Directed testbench for serial_digit_recoder with WIDTH = 8.
// The bench plays the upstream shift register (m follows the bench's own
// expectation of shift_en) and the downstream consumer (dig_ready).
// Expected digits are hand-computed tables packed as {d4,d3,d2,d1,d0}, each
// digit encoded {neg,one,two}.
// -----------------------------------------------------------------------------
module tb_serial_digit_recoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] m = 2'b00;
  logic       dig_ready = 1'b0;
  logic       shift_en, dig_valid, dig_neg, dig_one, dig_two, busy, done;
  logic [2:0] dig_idx;
  logic [9:0] obs;

  int tests_run = 0;
  int tests_failed = 0;

  serial_digit_recoder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .m         (m),
    .shift_en  (shift_en),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_neg   (dig_neg),
    .dig_one   (dig_one),
    .dig_two   (dig_two),
    .dig_idx   (dig_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Observed vector: {valid, busy, done, shift_en, neg, one, two, idx[2:0]}
  assign obs = {dig_valid, busy, done, shift_en, dig_neg, dig_one, dig_two, dig_idx};

  // Runs one operand: start, NDIG+1 digits with an optional stall, done pulse.
  task automatic run_op(input string name, input logic [7:0] y, input logic [14:0] exp,
                        input int stall_at, input int stall_len, input logic hold_start);
    int         sidx;
    int         got;
    int         cyc;
    int         stalled;
    int         sum;
    int         pw;
    logic [2:0] f;
    logic [9:0] e;
    sidx = 0; got = 0; cyc = 0; stalled = 0; sum = 0; pw = 1;

    @(negedge clk);
    m = y[1:0]; dig_ready = 1'b1; start = 1'b1;
    #1;
    tests_run++;
    if (obs !== 10'b0) begin
      tests_failed++;
      $display("FAIL %s idle_before_start: got %b expected %b", name, obs, 10'b0);
    end

    @(negedge clk);
    start = hold_start;
    while (got < 5 && cyc < 40) begin
      m = (sidx < 4) ? y[2*sidx +: 2] : 2'b00;
      dig_ready = !(got == stall_at && stalled < stall_len);
      #1;
      f = exp[3*got +: 3];
      e = {1'b1, 1'b1, 1'b0, (got < 4) && dig_ready, f, 3'(got)};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL %s digit%0d cycle%0d: got %b expected %b", name, got, cyc, obs, e);
      end
      if (e[6]) sidx++;
      if (dig_ready) begin
        if (f[2] && f[1])      sum -= pw;
        else if (f[1])         sum += pw;
        else if (f[0])         sum += 2 * pw;
        pw  = pw * 4;
        got++;
      end else begin
        stalled++;
      end
      cyc++;
      @(negedge clk);
    end

    tests_run++;
    if (cyc !== 5 + stall_len) begin
      tests_failed++;
      $display("FAIL %s digit_cycles: got %0d expected %0d", name, cyc, 5 + stall_len);
    end

    #1;
    tests_run++;
    if (obs !== 10'b0010000000) begin
      tests_failed++;
      $display("FAIL %s done_pulse: got %b expected %b", name, obs, 10'b0010000000);
    end

    tests_run++;
    if (sum !== int'(y)) begin
      tests_failed++;
      $display("FAIL %s digit_sum: got %0d expected %0d", name, sum, int'(y));
    end

    @(negedge clk);
    m = y[1:0];
    #1;
    tests_run++;
    if (obs !== 10'b0) begin
      tests_failed++;
      $display("FAIL %s idle_after_done: got %b expected %b", name, obs, 10'b0);
    end

    if (hold_start) begin
      @(negedge clk);
      #1;
      e = {1'b1, 1'b1, 1'b0, 1'b1, exp[2:0], 3'd0};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL %s restart_run: got %b expected %b", name, obs, e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (obs !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 10'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %b expected %b", obs, 10'b0);
    end
  endtask

  task automatic test_basic();
    run_op("y6E", 8'h6E, 15'b000_001_110_110_001, -1, 0, 1'b0);
  endtask

  task automatic test_all_ones();
    run_op("yFF", 8'hFF, 15'b010_000_000_000_110, -1, 0, 1'b0);
  endtask

  task automatic test_zero();
    run_op("y00", 8'h00, 15'b000_000_000_000_000, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op("y6E_stall", 8'h6E, 15'b000_001_110_110_001, 1, 3, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    m = 2'b11; dig_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;            // RUN idx0 accepted at next edge
    @(negedge clk);          // RUN idx1 accepted at next edge
    @(negedge clk);          // RUN idx2, carry is 1
    #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_run_outputs: got %b expected %b", obs, 10'b0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (obs !== 10'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_run_hold%0d: got %b expected %b", i, obs, 10'b0);
      end
    end
    rst = 1'b1;
    run_op("yFF_after_reset", 8'hFF, 15'b010_000_000_000_110, -1, 0, 1'b0);
  endtask

  task automatic test_start_held();
    run_op("y6E_start_held", 8'h6E, 15'b000_001_110_110_001, -1, 0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_zero();
    test_backpressure();
    test_reset_mid_run();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
